// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: fp32 field layout,
// frame-sink state encoding and a NaN helper.
package conv_pkg;

  localparam int DATA_W    = 32;
  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic fp32_is_nan(input logic [DATA_W-1:0] x);
    return (x[FP_MAN_W +: FP_EXP_W] == {FP_EXP_W{1'b1}}) &&
           (x[FP_MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_max_cmp.sv
// Combinational fp32 "a greater than b" using sign-magnitude ordering;
// -0 and +0 compare equal. NaN filtering is left to the caller.
module fp32_max_cmp
  import conv_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_gt_b
);

  localparam int SIGN_BIT = DATA_W - FP_SIGN_W;
  localparam int MAG_W    = FP_EXP_W + FP_MAN_W;

  logic             sa, sb;
  logic [MAG_W-1:0] ma, mb;

  always_comb begin
    sa = a[SIGN_BIT];
    sb = b[SIGN_BIT];
    ma = a[MAG_W-1:0];
    mb = b[MAG_W-1:0];
    a_gt_b = 1'b0;
    if (ma == '0 && mb == '0) begin
      a_gt_b = 1'b0;
    end else if (sa != sb) begin
      a_gt_b = !sa;
    end else if (!sa) begin
      a_gt_b = (ma > mb);
    end else begin
      a_gt_b = (ma < mb);
    end
  end

endmodule

// File: rtl/conv_frame_sink.sv
// Captures one DxD raster frame from a conv engine pixel stream into a frame
// memory write port, tracking the frame maximum, pixel count and stray pixels.
module conv_frame_sink
  import conv_pkg::*;
#(
  parameter int D          = 299,
  parameter int data_width = 32,
  parameter int ADDR_W     = $clog2(D*D)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic [data_width-1:0] max_val,
  output logic [ADDR_W:0]       pxl_count,
  output logic                  err_stray
);

  localparam int CW    = (D > 1) ? $clog2(D) : 1;
  localparam int CNT_W = ADDR_W + 1;

  state_t                  state;
  logic [CW-1:0]           col, row;
  logic [ADDR_W-1:0]       lin;
  logic [data_width-1:0]   run_max;
  logic                    has_max;

  logic                    accept, last_pxl, pxl_gt, take_max;
  logic [data_width-1:0]   max_next;

  fp32_max_cmp u_cmp (
    .a      (pxl_in),
    .b      (run_max),
    .a_gt_b (pxl_gt)
  );

  // A start in the same cycle always wins over the pixel strobe.
  assign accept   = (state == CAPTURE) && valid_in && !start;
  assign last_pxl = (col == CW'(D-1)) && (row == CW'(D-1));
  assign take_max = accept && !fp32_is_nan(pxl_in) && (!has_max || pxl_gt);
  assign max_next = take_max ? pxl_in : run_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      lin        <= '0;
      run_max    <= '0;
      has_max    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      max_val    <= '0;
      pxl_count  <= '0;
      err_stray  <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (start && state != DONE) begin
        state     <= CAPTURE;
        busy      <= 1'b1;
        col       <= '0;
        row       <= '0;
        lin       <= '0;
        pxl_count <= '0;
        run_max   <= '0;
        has_max   <= 1'b0;
        err_stray <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_in) err_stray <= 1'b1;
          end
          CAPTURE: begin
            if (accept) begin
              mem_we    <= 1'b1;
              mem_addr  <= lin;
              mem_wdata <= pxl_in;
              pxl_count <= pxl_count + CNT_W'(1);
              run_max   <= max_next;
              has_max   <= has_max | take_max;
              if (last_pxl) begin
                state      <= DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                max_val    <= max_next;
              end else begin
                lin <= lin + ADDR_W'(1);
                if (col == CW'(D-1)) begin
                  col <= '0;
                  row <= row + CW'(1);
                end else begin
                  col <= col + CW'(1);
                end
              end
            end
          end
          DONE: begin
            // Anything strobed right after the last pixel is an excess pixel.
            if (valid_in) err_stray <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
